// File: rtl/if_id_queue_if.sv
// Fetch/decode bus for if_id_queue. The slave modport is the queue side;
// the master modport is the fetch/decode/hazard side driving it.
interface if_id_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          i_flush;
  logic          i_stall;
  logic          i_inst_valid;
  logic [31:0]   i_inst;
  logic [31:0]   i_fetch_pc;
  logic          o_stall_fetch;
  logic          o_valid;
  logic [31:0]   o_inst;
  logic [31:0]   o_pc;
  logic [31:0]   o_pc_plus_4;
  logic [4:0]    o_rs1;
  logic [4:0]    o_rs2;
  logic          o_uses_rs1;
  logic          o_uses_rs2;
  logic [CW-1:0] o_count;
  logic          o_overflow;

  modport slave (
    input  i_flush, i_stall, i_inst_valid, i_inst, i_fetch_pc,
    output o_stall_fetch, o_valid, o_inst, o_pc, o_pc_plus_4,
           o_rs1, o_rs2, o_uses_rs1, o_uses_rs2, o_count, o_overflow
  );

  modport master (
    output i_flush, i_stall, i_inst_valid, i_inst, i_fetch_pc,
    input  o_stall_fetch, o_valid, o_inst, o_pc, o_pc_plus_4,
           o_rs1, o_rs2, o_uses_rs1, o_uses_rs2, o_count, o_overflow
  );
endinterface

// File: rtl/if_id_queue.sv
// First-word-fall-through IF/ID instruction queue with flush and fetch back-pressure.
// Optional register-operand predecode is enabled by defining IFQ_PREDECODE_EN.
module if_id_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic           i_clk,
  input  logic           i_rst,
  if_id_queue_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] HIGH_CNT  = CW'(DEPTH - 1);

  logic [31:0]   r_inst_mem [DEPTH];
  logic [31:0]   r_pc_mem   [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic w_valid;
  logic w_full;
  logic w_deq;
  logic w_enq;
  logic w_drop;

  assign w_valid = (r_count != {CW{1'b0}});
  assign w_full  = (r_count == FULL_CNT);
  assign w_deq   = w_valid && !bus.i_stall && !bus.i_flush;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign w_enq   = bus.i_inst_valid && (!w_full || w_deq) && !bus.i_flush;
  assign w_drop  = bus.i_inst_valid && w_full && !w_deq && !bus.i_flush;

  // Payload storage; never cleared, empty-state muxing hides stale data.
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_inst_mem[r_wr_ptr] <= bus.i_inst;
      r_pc_mem[r_wr_ptr]   <= bus.i_fetch_pc;
    end
  end

  // Pointer and occupancy control; flush discards same-cycle enqueue/dequeue.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else if (bus.i_flush) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag; only reset clears it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // Head presentation; NOP and PC 0 while empty.
  always_comb begin
    if (w_valid) begin
      bus.o_inst = r_inst_mem[r_rd_ptr];
      bus.o_pc   = r_pc_mem[r_rd_ptr];
    end else begin
      bus.o_inst = NOP_INST;
      bus.o_pc   = 32'h00000000;
    end
  end

  assign bus.o_pc_plus_4   = bus.o_pc + 32'd4;
  assign bus.o_valid       = w_valid;
  assign bus.o_count       = r_count;
  assign bus.o_overflow    = r_overflow;
  // Held one entry early so the word already in flight from fetch still fits.
  assign bus.o_stall_fetch = (r_count >= HIGH_CNT);

`ifdef IFQ_PREDECODE_EN
  logic [4:0] r_rs1_mem [DEPTH];
  logic [4:0] r_rs2_mem [DEPTH];
  logic [1:0] r_use_mem [DEPTH];

  function automatic logic f_uses_rs1(input logic [6:0] op);
    logic v;
    case (op)
      7'b0110011, 7'b0010011, 7'b0000011,
      7'b0100011, 7'b1100011, 7'b1100111: v = 1'b1;
      default:                            v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic logic f_uses_rs2(input logic [6:0] op);
    logic v;
    case (op)
      7'b0110011, 7'b0100011, 7'b1100011: v = 1'b1;
      default:                            v = 1'b0;
    endcase
    return v;
  endfunction

  // Predecode computed once at enqueue and stored beside the payload.
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_rs1_mem[r_wr_ptr] <= bus.i_inst[19:15];
      r_rs2_mem[r_wr_ptr] <= bus.i_inst[24:20];
      r_use_mem[r_wr_ptr] <= {f_uses_rs2(bus.i_inst[6:0]), f_uses_rs1(bus.i_inst[6:0])};
    end
  end

  // Predecode head presentation, zero while empty.
  always_comb begin
    if (w_valid) begin
      bus.o_rs1      = r_rs1_mem[r_rd_ptr];
      bus.o_rs2      = r_rs2_mem[r_rd_ptr];
      bus.o_uses_rs1 = r_use_mem[r_rd_ptr][0];
      bus.o_uses_rs2 = r_use_mem[r_rd_ptr][1];
    end else begin
      bus.o_rs1      = 5'd0;
      bus.o_rs2      = 5'd0;
      bus.o_uses_rs1 = 1'b0;
      bus.o_uses_rs2 = 1'b0;
    end
  end
`else
  assign bus.o_rs1      = 5'd0;
  assign bus.o_rs2      = 5'd0;
  assign bus.o_uses_rs1 = 1'b0;
  assign bus.o_uses_rs2 = 1'b0;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: a queue-based reference model tracks the
// expected contents; a negedge monitor compares every DUT output against it.
module tb_if_id_queue;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  ent_t sb[$];
  logic m_ovf = 1'b0;
  logic started = 1'b0;

  if_id_queue_if #(.DEPTH(DEPTH)) bus ();

  if_id_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_uses1(input logic [31:0] ins);
`ifdef IFQ_PREDECODE_EN
    return ins[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_uses2(input logic [31:0] ins);
`ifdef IFQ_PREDECODE_EN
    return ins[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: the queue holds exactly the words the decode stage is still owed.
  always @(posedge i_clk) begin
    if (i_rst) begin
      sb.delete();
      m_ovf   <= 1'b0;
      started <= 1'b1;
    end else if (bus.i_flush) begin
      sb.delete();
    end else begin
      if (sb.size() != 0 && !bus.i_stall) void'(sb.pop_front());
      if (bus.i_inst_valid) begin
        if (sb.size() < DEPTH) sb.push_back('{inst: bus.i_inst, pc: bus.i_fetch_pc});
        else m_ovf <= 1'b1;
      end
    end
  end

  // Monitor: compare presented head and status against the model every cycle.
  always @(negedge i_clk) begin
    if (started) begin
      logic [31:0] e_inst;
      logic [31:0] e_pc;
      logic [31:0] e_rs1;
      logic [31:0] e_rs2;
      e_inst = NOP;
      e_pc   = 32'd0;
      if (sb.size() != 0) begin
        e_inst = sb[0].inst;
        e_pc   = sb[0].pc;
      end
`ifdef IFQ_PREDECODE_EN
      e_rs1 = (sb.size() != 0) ? {27'd0, e_inst[19:15]} : 32'd0;
      e_rs2 = (sb.size() != 0) ? {27'd0, e_inst[24:20]} : 32'd0;
`else
      e_rs1 = 32'd0;
      e_rs2 = 32'd0;
`endif
      chk("valid", {31'd0, bus.o_valid}, (sb.size() != 0) ? 32'd1 : 32'd0);
      chk("count", {{(32-CW){1'b0}}, bus.o_count}, sb.size());
      chk("stall_fetch", {31'd0, bus.o_stall_fetch}, (sb.size() >= DEPTH - 1) ? 32'd1 : 32'd0);
      chk("overflow", {31'd0, bus.o_overflow}, {31'd0, m_ovf});
      chk("inst", bus.o_inst, e_inst);
      chk("pc", bus.o_pc, e_pc);
      chk("pc_plus_4", bus.o_pc_plus_4, e_pc + 32'd4);
      chk("rs1", {27'd0, bus.o_rs1}, e_rs1);
      chk("rs2", {27'd0, bus.o_rs2}, e_rs2);
      chk("uses_rs1", {31'd0, bus.o_uses_rs1}, {31'd0, (sb.size() != 0) && m_uses1(e_inst)});
      chk("uses_rs2", {31'd0, bus.o_uses_rs2}, {31'd0, (sb.size() != 0) && m_uses2(e_inst)});
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic st, input logic fl);
    bus.i_inst_valid = v;
    bus.i_inst       = ins;
    bus.i_fetch_pc   = pc;
    bus.i_stall      = st;
    bus.i_flush      = fl;
    @(posedge i_clk);
    #1;
  endtask

  logic [31:0] exp_pcs [5];
  logic [6:0]  ops     [8];
  logic [31:0] rnd_inst;
  logic [31:0] rnd_pc;
  logic        pd_en;

  initial begin
`ifdef IFQ_PREDECODE_EN
    pd_en = 1'b1;
`else
    pd_en = 1'b0;
`endif
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1100111, 7'b1101111, 7'b0110111};
    exp_pcs = '{32'h4, 32'h8, 32'hC, 32'h10, 32'h0};
    i_rst = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    i_rst = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("idle_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("idle_inst", bus.o_inst, 32'h00000013);
    chk("idle_pc4", bus.o_pc_plus_4, 32'd4);
    chk("idle_stall_fetch", {31'd0, bus.o_stall_fetch}, 32'd0);

    drive(1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0);
    chk("push_valid", {31'd0, bus.o_valid}, 32'd1);
    chk("push_inst", bus.o_inst, 32'h00500093);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("push_drained", {31'd0, bus.o_valid}, 32'd0);

    drive(1'b1, 32'h00000013, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 32'h00000013, 32'h4, 1'b1, 1'b0);
    drive(1'b1, 32'h00000013, 32'h8, 1'b1, 1'b0);
    chk("three_stall_fetch", {31'd0, bus.o_stall_fetch}, 32'd1);
    drive(1'b1, 32'h00000013, 32'hC, 1'b1, 1'b0);
    chk("full_count", {{(32-CW){1'b0}}, bus.o_count}, 32'd4);
    chk("full_head_pc", bus.o_pc, 32'h0);
    drive(1'b1, 32'h00000013, 32'h14, 1'b1, 1'b0);
    chk("overflow_set", {31'd0, bus.o_overflow}, 32'd1);
    chk("overflow_count", {{(32-CW){1'b0}}, bus.o_count}, 32'd4);
    drive(1'b1, 32'h00000013, 32'h10, 1'b0, 1'b0);
    chk("full_pushdeq_count", {{(32-CW){1'b0}}, bus.o_count}, 32'd4);
    for (int i = 0; i < 5; i++) begin
      chk("drain_pc", bus.o_pc, exp_pcs[i]);
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    end
    chk("drain_empty", {31'd0, bus.o_valid}, 32'd0);

    drive(1'b1, 32'h00000013, 32'h20, 1'b1, 1'b0);
    drive(1'b1, 32'h00000013, 32'h24, 1'b1, 1'b0);
    drive(1'b1, 32'h00000013, 32'h28, 1'b1, 1'b0);
    drive(1'b1, 32'h00000013, 32'h40, 1'b1, 1'b1);
    chk("flush_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("flush_count", {{(32-CW){1'b0}}, bus.o_count}, 32'd0);
    drive(1'b1, 32'h00000013, 32'h100, 1'b0, 1'b0);
    chk("after_flush_pc", bus.o_pc, 32'h100);
    chk("flush_keeps_ovf", {31'd0, bus.o_overflow}, 32'd1);

    drive(1'b1, 32'h002081B3, 32'h200, 1'b1, 1'b1);
    drive(1'b1, 32'h002081B3, 32'h200, 1'b1, 1'b0);
    chk("pd_rs1", {27'd0, bus.o_rs1}, pd_en ? 32'd1 : 32'd0);
    chk("pd_rs2", {27'd0, bus.o_rs2}, pd_en ? 32'd2 : 32'd0);
    chk("pd_uses_rs2", {31'd0, bus.o_uses_rs2}, {31'd0, pd_en});
    drive(1'b1, 32'h000000EF, 32'h204, 1'b0, 1'b0);
    chk("pd_jal_uses_rs1", {31'd0, bus.o_uses_rs1}, 32'd0);

    drive(1'b1, 32'h00000013, 32'h300, 1'b1, 1'b0);
    i_rst = 1'b1;
    drive(1'b1, 32'h00000013, 32'h304, 1'b1, 1'b1);
    i_rst = 1'b0;
    chk("midrst_count", {{(32-CW){1'b0}}, bus.o_count}, 32'd0);
    chk("midrst_ovf", {31'd0, bus.o_overflow}, 32'd0);

    rnd_pc = 32'h1000;
    for (int c = 0; c < 3000; c++) begin
      rnd_inst = $urandom();
      if ($urandom_range(0, 3) != 0) rnd_inst[6:0] = ops[$urandom_range(0, 7)];
      i_rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 9) < 6, rnd_inst, rnd_pc,
            $urandom_range(0, 9) < 3, $urandom_range(0, 29) == 0);
      rnd_pc = rnd_pc + 32'd4;
    end
    i_rst = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
